// File: rtl/onets_led_sched_if.sv
// Signal bundle between the heartbeat/enable sources and the LED slot scheduler.
interface onets_led_sched_if;
   logic [3:0] hb_in;
   logic [3:0] src_en;
   logic [1:0] pl_led;
   logic [1:0] sel_idx;
   logic       sel_valid;
   logic [3:0] src_alive;
   logic       slot_strobe;

   modport master (
      output hb_in,
      output src_en,
      input  pl_led,
      input  sel_idx,
      input  sel_valid,
      input  src_alive,
      input  slot_strobe
   );

   modport slave (
      input  hb_in,
      input  src_en,
      output pl_led,
      output sel_idx,
      output sel_valid,
      output src_alive,
      output slot_strobe
   );
endinterface

// File: rtl/onets_led_sched.sv
// Time-multiplexes four heartbeat sources onto two LEDs: one slot per enabled source,
// dark gap between slots, with per-source liveness watchdogs.
module onets_led_sched #(
   parameter int unsigned NUM_SRC      = 4,
   parameter int unsigned SLOT_CYCLES  = 125000000,
   parameter int unsigned GAP_CYCLES   = 12500000,
   parameter int unsigned ALIVE_CYCLES = 62500000
) (
   input logic              bd_fclk0_125m,
   input logic              bd_reset,
   onets_led_sched_if.slave bus
);

   localparam int unsigned SlotW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
   localparam int unsigned GapW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned WdW   = $clog2(ALIVE_CYCLES + 1);

   localparam logic [SlotW-1:0] SlotLast = SlotW'(SLOT_CYCLES - 1);
   localparam logic [GapW-1:0]  GapLast  = GapW'(GAP_CYCLES - 1);
   localparam logic [WdW-1:0]   WdMax    = WdW'(ALIVE_CYCLES);

   typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

   state_e           state_q;
   logic [3:0]       hb_s1_q, hb_s2_q, hb_hist_q;
   logic [3:0]       hb_edge;
   logic [WdW-1:0]   wd_q [NUM_SRC];
   logic [3:0]       src_alive_q;
   logic [1:0]       last_idx_q, sel_idx_q, nxt_idx, cand;
   logic [1:0]       pl_led_q;
   logic             sel_valid_q, slot_strobe_q;
   logic [SlotW-1:0] slot_cnt_q;
   logic [GapW-1:0]  gap_cnt_q;

   assign hb_edge = hb_s2_q ^ hb_hist_q;

   always_ff @(posedge bd_fclk0_125m) begin
      if (bd_reset) begin
         hb_s1_q     <= '0;
         hb_s2_q     <= '0;
         hb_hist_q   <= '0;
         src_alive_q <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            wd_q[i] <= WdMax;
         end
      end else begin
         hb_s1_q   <= bus.hb_in;
         hb_s2_q   <= hb_s1_q;
         hb_hist_q <= hb_s2_q;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (hb_edge[i]) begin
               wd_q[i] <= '0;
            end else if (wd_q[i] != WdMax) begin
               wd_q[i] <= wd_q[i] + WdW'(1);
            end
            src_alive_q[i] <= (wd_q[i] < WdMax);
         end
      end
   end

   // Round-robin pick: lowest upward offset wins; offset NUM_SRC lands back on last_idx.
   always_comb begin
      nxt_idx = last_idx_q;
      cand    = last_idx_q;
      for (int k = int'(NUM_SRC); k >= 1; k--) begin
         cand = last_idx_q + 2'(k);
         if (bus.src_en[cand]) begin
            nxt_idx = cand;
         end
      end
   end

   always_ff @(posedge bd_fclk0_125m) begin
      if (bd_reset) begin
         state_q       <= StIdle;
         pl_led_q      <= 2'b00;
         sel_idx_q     <= 2'd0;
         sel_valid_q   <= 1'b0;
         slot_strobe_q <= 1'b0;
         last_idx_q    <= 2'd3;
         slot_cnt_q    <= '0;
         gap_cnt_q     <= '0;
      end else begin
         slot_strobe_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               pl_led_q    <= 2'b00;
               sel_valid_q <= 1'b0;
               if (|bus.src_en) begin
                  state_q       <= StShow;
                  sel_idx_q     <= nxt_idx;
                  last_idx_q    <= nxt_idx;
                  slot_strobe_q <= 1'b1;
                  sel_valid_q   <= 1'b1;
                  slot_cnt_q    <= '0;
                  pl_led_q      <= {src_alive_q[nxt_idx], hb_s2_q[nxt_idx]};
               end
            end
            StShow: begin
               // Disabling the shown source cuts the slot short.
               if (!bus.src_en[sel_idx_q] || slot_cnt_q == SlotLast) begin
                  state_q     <= StGap;
                  gap_cnt_q   <= '0;
                  pl_led_q    <= 2'b00;
                  sel_valid_q <= 1'b0;
               end else begin
                  slot_cnt_q <= slot_cnt_q + SlotW'(1);
                  pl_led_q   <= {src_alive_q[sel_idx_q], hb_s2_q[sel_idx_q]};
               end
            end
            StGap: begin
               pl_led_q    <= 2'b00;
               sel_valid_q <= 1'b0;
               if (gap_cnt_q == GapLast) begin
                  if (|bus.src_en) begin
                     state_q       <= StShow;
                     sel_idx_q     <= nxt_idx;
                     last_idx_q    <= nxt_idx;
                     slot_strobe_q <= 1'b1;
                     sel_valid_q   <= 1'b1;
                     slot_cnt_q    <= '0;
                     pl_led_q      <= {src_alive_q[nxt_idx], hb_s2_q[nxt_idx]};
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + GapW'(1);
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.pl_led      = pl_led_q;
   assign bus.sel_idx     = sel_idx_q;
   assign bus.sel_valid   = sel_valid_q;
   assign bus.src_alive   = src_alive_q;
   assign bus.slot_strobe = slot_strobe_q;

endmodule

// File: tb/tb_onets_led_sched.sv
// Directed bench for onets_led_sched with SLOT=8, GAP=2, ALIVE=16.
module tb_onets_led_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #4 clk = ~clk;

   onets_led_sched_if ifc ();

   logic [3:0] hb_tog  = 4'b0000;
   logic [3:0] hb_auto = 4'b0000;
   logic [3:0] hb_kick = 4'b0000;
   int         tgl_cnt = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   assign ifc.hb_in = hb_tog ^ hb_kick;

   // Sources in hb_auto toggle every 4 cycles.
   always @(negedge clk) begin
      tgl_cnt <= (tgl_cnt == 3) ? 0 : tgl_cnt + 1;
      hb_tog  <= (tgl_cnt == 3) ? (hb_tog ^ hb_auto) : hb_tog;
   end

   onets_led_sched #(
      .NUM_SRC      (4),
      .SLOT_CYCLES  (8),
      .GAP_CYCLES   (2),
      .ALIVE_CYCLES (16)
   ) dut (
      .bd_fclk0_125m (clk),
      .bd_reset      (rst),
      .bus           (ifc)
   );

   // Non-toggling heartbeat inputs are forced to 0 before reset is released.
   task automatic do_reset(input logic [3:0] en, input logic [3:0] auto);
      rst        = 1'b1;
      ifc.src_en = en;
      hb_auto    = auto;
      @(negedge clk);
      @(negedge clk);
      #1;
      hb_kick = hb_tog & ~auto;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset(4'b0000, 4'b0000);
      n_checks++;
      if (ifc.pl_led !== 2'b00) begin
         n_fail++; $display("FAIL reset_pl_led got %b expected 00", ifc.pl_led);
      end
      n_checks++;
      if (ifc.sel_idx !== 2'd0) begin
         n_fail++; $display("FAIL reset_sel_idx got %0d expected 0", ifc.sel_idx);
      end
      n_checks++;
      if (ifc.sel_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_sel_valid got %b expected 0", ifc.sel_valid);
      end
      n_checks++;
      if (ifc.slot_strobe !== 1'b0) begin
         n_fail++; $display("FAIL reset_strobe got %b expected 0", ifc.slot_strobe);
      end
      n_checks++;
      if (ifc.src_alive !== 4'b0000) begin
         n_fail++; $display("FAIL reset_src_alive got %b expected 0000", ifc.src_alive);
      end
   endtask

   task automatic test_idle();
      do_reset(4'b0000, 4'b0000);
      for (int cyc = 1; cyc <= 20; cyc++) begin
         @(negedge clk);
         n_checks++;
         if (ifc.sel_valid !== 1'b0 || ifc.pl_led !== 2'b00 || ifc.slot_strobe !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet cyc=%0d got valid=%b led=%b strobe=%b expected 0/00/0",
                     cyc, ifc.sel_valid, ifc.pl_led, ifc.slot_strobe);
         end
      end
      ifc.src_en = 4'b1000;
      @(negedge clk);
      n_checks++;
      if (ifc.sel_valid !== 1'b1 || ifc.sel_idx !== 2'd3 || ifc.slot_strobe !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_wake got valid=%b idx=%0d strobe=%b expected 1/3/1",
                  ifc.sel_valid, ifc.sel_idx, ifc.slot_strobe);
      end
   endtask

   task automatic test_rotation();
      int c;
      logic       exp_valid, exp_strobe;
      logic [1:0] exp_idx;
      do_reset(4'b1111, 4'b1111);
      for (int cyc = 1; cyc <= 45; cyc++) begin
         @(negedge clk);
         c          = cyc - 1;
         exp_valid  = (c % 10) < 8;
         exp_strobe = (c % 10) == 0;
         exp_idx    = 2'((c / 10) % 4);
         n_checks++;
         if (ifc.sel_valid !== exp_valid || ifc.slot_strobe !== exp_strobe) begin
            n_fail++;
            $display("FAIL rot_timing cyc=%0d got valid=%b strobe=%b expected %b/%b",
                     cyc, ifc.sel_valid, ifc.slot_strobe, exp_valid, exp_strobe);
         end
         n_checks++;
         if (exp_valid && ifc.sel_idx !== exp_idx) begin
            n_fail++;
            $display("FAIL rot_idx cyc=%0d got %0d expected %0d", cyc, ifc.sel_idx, exp_idx);
         end else if (!exp_valid && ifc.pl_led !== 2'b00) begin
            n_fail++;
            $display("FAIL rot_gap_led cyc=%0d got %b expected 00", cyc, ifc.pl_led);
         end
      end
   endtask

   task automatic test_single_source();
      int c;
      logic exp_valid, exp_strobe;
      do_reset(4'b0100, 4'b0000);
      for (int cyc = 1; cyc <= 35; cyc++) begin
         @(negedge clk);
         c          = cyc - 1;
         exp_valid  = (c % 10) < 8;
         exp_strobe = (c % 10) == 0;
         n_checks++;
         if (ifc.sel_valid !== exp_valid || ifc.slot_strobe !== exp_strobe) begin
            n_fail++;
            $display("FAIL single_timing cyc=%0d got valid=%b strobe=%b expected %b/%b",
                     cyc, ifc.sel_valid, ifc.slot_strobe, exp_valid, exp_strobe);
         end
         if (exp_valid) begin
            n_checks++;
            if (ifc.sel_idx !== 2'd2) begin
               n_fail++;
               $display("FAIL single_idx cyc=%0d got %0d expected 2", cyc, ifc.sel_idx);
            end
         end
      end
   endtask

   task automatic test_latency();
      do_reset(4'b0001, 4'b0000);
      for (int cyc = 1; cyc <= 6; cyc++) begin
         @(negedge clk);
         if (cyc == 2) hb_kick[0] = ~hb_kick[0];
         if (cyc >= 3 && cyc <= 5) begin
            n_checks++;
            if (ifc.pl_led[0] !== (cyc == 5)) begin
               n_fail++;
               $display("FAIL latency cyc=%0d got %b expected %b", cyc, ifc.pl_led[0], cyc == 5);
            end
         end
      end
   endtask

   task automatic test_early_term();
      do_reset(4'b1111, 4'b0000);
      for (int cyc = 1; cyc <= 17; cyc++) begin
         @(negedge clk);
         if (cyc == 14) begin
            n_checks++;
            if (ifc.sel_valid !== 1'b1 || ifc.sel_idx !== 2'd1) begin
               n_fail++;
               $display("FAIL early_pre got valid=%b idx=%0d expected 1/1",
                        ifc.sel_valid, ifc.sel_idx);
            end
            ifc.src_en = 4'b1101;
         end
         if (cyc == 15 || cyc == 16) begin
            n_checks++;
            if (ifc.sel_valid !== 1'b0 || ifc.pl_led !== 2'b00) begin
               n_fail++;
               $display("FAIL early_gap cyc=%0d got valid=%b led=%b expected 0/00",
                        cyc, ifc.sel_valid, ifc.pl_led);
            end
         end
         if (cyc == 17) begin
            n_checks++;
            if (ifc.sel_valid !== 1'b1 || ifc.slot_strobe !== 1'b1 || ifc.sel_idx !== 2'd2) begin
               n_fail++;
               $display("FAIL early_next got valid=%b strobe=%b idx=%0d expected 1/1/2",
                        ifc.sel_valid, ifc.slot_strobe, ifc.sel_idx);
            end
         end
      end
   endtask

   task automatic test_watchdog();
      do_reset(4'b0001, 4'b1110);
      for (int cyc = 1; cyc <= 34; cyc++) begin
         @(negedge clk);
         if (cyc == 2 || cyc == 30) hb_kick[0] = ~hb_kick[0];
         if (cyc == 5 || cyc == 6 || cyc == 21 || cyc == 22 || cyc == 33 || cyc == 34) begin
            n_checks++;
            if (ifc.src_alive[0] !== (cyc == 6 || cyc == 21 || cyc == 34)) begin
               n_fail++;
               $display("FAIL wd_alive0 cyc=%0d got %b expected %b", cyc, ifc.src_alive[0],
                        cyc == 6 || cyc == 21 || cyc == 34);
            end
         end
         if (cyc == 15) begin
            n_checks++;
            if (ifc.pl_led[1] !== 1'b1 || ifc.sel_valid !== 1'b1) begin
               n_fail++;
               $display("FAIL wd_led_alive got led1=%b valid=%b expected 1/1",
                        ifc.pl_led[1], ifc.sel_valid);
            end
         end
         if (cyc == 20) begin
            n_checks++;
            if (ifc.src_alive[3:1] !== 3'b111) begin
               n_fail++;
               $display("FAIL wd_disabled_alive got %b expected 111", ifc.src_alive[3:1]);
            end
         end
         if (cyc == 25) begin
            n_checks++;
            if (ifc.pl_led[1] !== 1'b0 || ifc.sel_valid !== 1'b1 || ifc.sel_idx !== 2'd0) begin
               n_fail++;
               $display("FAIL wd_led_dead got led1=%b valid=%b idx=%0d expected 0/1/0",
                        ifc.pl_led[1], ifc.sel_valid, ifc.sel_idx);
            end
         end
      end
   endtask

   task automatic test_reset_mid_show();
      do_reset(4'b1111, 4'b1111);
      repeat (25) @(negedge clk);
      n_checks++;
      if (ifc.sel_valid !== 1'b1 || ifc.sel_idx !== 2'd2) begin
         n_fail++;
         $display("FAIL midrst_pre got valid=%b idx=%0d expected 1/2", ifc.sel_valid, ifc.sel_idx);
      end
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (ifc.pl_led !== 2'b00 || ifc.sel_idx !== 2'd0 || ifc.sel_valid !== 1'b0 ||
          ifc.slot_strobe !== 1'b0 || ifc.src_alive !== 4'b0000) begin
         n_fail++;
         $display("FAIL midrst_vals got led=%b idx=%0d valid=%b strobe=%b alive=%b expected 00/0/0/0/0000",
                  ifc.pl_led, ifc.sel_idx, ifc.sel_valid, ifc.slot_strobe, ifc.src_alive);
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (ifc.sel_valid !== 1'b1 || ifc.slot_strobe !== 1'b1 || ifc.sel_idx !== 2'd0) begin
         n_fail++;
         $display("FAIL midrst_first got valid=%b strobe=%b idx=%0d expected 1/1/0",
                  ifc.sel_valid, ifc.slot_strobe, ifc.sel_idx);
      end
   endtask

   initial begin
      ifc.src_en = 4'b0000;
      test_reset();
      test_idle();
      test_rotation();
      test_single_source();
      test_latency();
      test_early_term();
      test_watchdog();
      test_reset_mid_show();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/onets_led_sched.md
ONETS_LED_SCHED -- requirements
Module: onets_led_sched

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_SRC, 4, number of heartbeat sources (fixed at 4; index width 2).
- SLOT_CYCLES, 125000000, clock cycles one source is shown (1 s at 125 MHz).
- GAP_CYCLES, 12500000, cycles both LEDs are dark between slots.
- ALIVE_CYCLES, 62500000, cycles without a heartbeat edge before a source is declared dead.
REQ-002 Ports (name, direction, width, meaning), one per line:
- bd_fclk0_125m, input, 1, sole clock; all logic on its rising edge.
- bd_reset, input, 1, synchronous active-high reset.
- hb_in, input, 4, asynchronous heartbeat bits (counter MSBs from other clock domains).
- src_en, input, 4, synchronous per-source enable mask.
- pl_led, output, 2, LED drive: [0] selected heartbeat, [1] selected alive flag.
- sel_idx, output, 2, index of source currently shown.
- sel_valid, output, 1, high while in SHOW.
- src_alive, output, 4, per-source liveness.
- slot_strobe, output, 1, one-cycle pulse on every SHOW entry.
REQ-003 One clock; reset is synchronous and active-high.

Function
REQ-004 Each hb_in bit SHALL pass through a two-flop synchronizer followed by one history flop for edge detection; no other logic samples hb_in directly.
REQ-005 Any edge (either polarity) between sync stage 2 and the history flop SHALL count as a heartbeat edge.
REQ-006 Per source, a saturating watchdog counter SHALL clear to 0 on a heartbeat edge, otherwise increment, saturating at ALIVE_CYCLES.
REQ-007 src_alive[i] SHALL be high exactly when watchdog[i] < ALIVE_CYCLES; it is registered.
REQ-008 src_alive is independent of src_en.
REQ-009 The FSM SHALL have three states: IDLE, SHOW, GAP.
REQ-010 IDLE: pl_led=00, sel_valid=0; when src_en != 0, choose the next index and enter SHOW on the following cycle.
REQ-011 Next index SHALL be the first enabled index strictly after last_idx, searching upward with wrap 3->0. If last_idx is the only enabled index, it is chosen again.
REQ-012 SHOW: pl_led[0] = sync stage 2 of hb_in[sel_idx]; pl_led[1] = src_alive[sel_idx]; sel_valid=1. The slot counter counts 0..SLOT_CYCLES-1, then the FSM enters GAP.
REQ-013 If src_en[sel_idx] falls during SHOW, the FSM SHALL enter GAP on the next cycle (early termination).
REQ-014 GAP: pl_led=00, sel_valid=0 for GAP_CYCLES cycles, then the FSM re-evaluates:
- src_en == 0 -> IDLE;
- otherwise next index per REQ-011 -> SHOW.
REQ-015 On every SHOW entry: last_idx and sel_idx SHALL update to the chosen index, and slot_strobe SHALL pulse for exactly the first SHOW cycle.
REQ-016 All outputs SHALL be registered. In SHOW, latency from a hb_in change to pl_led[0] is 3 cycles (two sync flops plus the output register).
REQ-017 src_en changes during GAP or IDLE SHALL be honoured at the next decision point only; no glitching of outputs.
REQ-018 Slot and gap counters SHALL be sized by clog2 of their parameter and never wrap within a state.

Reset
REQ-019 On bd_reset: state=IDLE, pl_led=00, sel_idx=0, sel_valid=0, slot_strobe=0, last_idx=3 (so the first selection is index 0), synchronizer and history flops=0, watchdogs=ALIVE_CYCLES, src_alive=0000.
REQ-020 Reset asserted mid-SHOW or mid-GAP SHALL force the REQ-019 values on the next edge, with no partial slot continuation.

Verification (SLOT_CYCLES=8, GAP_CYCLES=2, ALIVE_CYCLES=16)
REQ-021 Reset, src_en=1111, hb_in toggling every 4 cycles on all sources -> slot_strobe pulses with sel_idx 0,1,2,3,0, spaced 10 cycles apart; pl_led=00 during each 2-cycle gap.
REQ-022 src_en=0100 only -> sel_idx stays 2, and SHOW is re-entered after every gap.
REQ-023 src_en[1] cleared at cycle 3 of index-1 SHOW -> GAP begins the next cycle; the following selection is 2.
REQ-024 hb_in[0] held constant -> src_alive[0] falls 16 cycles after the last edge and pl_led[1]=0 during source 0 slots; one toggle restores src_alive[0]=1 after 4 cycles.
REQ-025 src_en=0000 after reset -> IDLE, with pl_led=00 and sel_valid=0 indefinitely. Setting src_en=1000 gives SHOW with sel_idx=3 within 2 cycles.
REQ-026 bd_reset pulsed during SHOW -> all outputs return to REQ-019 values on the next edge, and the first selection afterwards is index 0.
